// File: rtl/corescore_axis_arb.sv
// Packet-granular round-robin arbiter: N byte streams share one registered AXI-S output stage.
// Grant 1 cycle after request, data 1 cycle after grant; o_tready drops combinationally when the sink stalls.
module corescore_axis_arb #(
    parameter int N = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [N*8-1:0] i_tdata,
    input  logic [N-1:0]   i_tlast,
    input  logic [N-1:0]   i_tvalid,
    output logic [N-1:0]   o_tready,
    output logic [7:0]     o_tdata,
    output logic           o_tlast,
    output logic           o_tvalid,
    input  logic           i_tready,
    output logic [N-1:0]   o_grant,
    output logic           o_busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);
    localparam logic [PW:0]   N_EXT    = (PW + 1)'(N);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [7:0]    tdata_q, tdata_d;
    logic          tlast_q, tlast_d;
    logic          tvalid_q, tvalid_d;

    logic          can_load;
    logic [N-1:0]  tready;
    logic          xfer;
    logic          req_found;
    logic [PW-1:0] req_idx;
    logic [PW:0]   cand;
    logic [PW-1:0] gnt_idx;
    logic [7:0]    sel_data;
    logic          sel_last;

    // Rotating priority search starting at ptr_q, wrapping at N-1.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + (PW + 1)'(i);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!req_found && i_tvalid[cand[PW-1:0]]) begin
                req_found = 1'b1;
                req_idx   = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        gnt_idx  = '0;
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                gnt_idx  = PW'(i);
                sel_data = i_tdata[8*i +: 8];
                sel_last = i_tlast[i];
            end
        end
    end

    assign can_load = !tvalid_q || i_tready;
    assign tready   = (state_q == ST_LOCKED) ? (grant_q & {N{can_load}}) : '0;
    assign xfer     = |(i_tvalid & tready);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;

        if (tvalid_q && i_tready) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_found) begin
                    grant_d = {{(N-1){1'b0}}, 1'b1} << req_idx;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (xfer) begin
                    tdata_d  = sel_data;
                    tlast_d  = sel_last;
                    tvalid_d = 1'b1;
                    // Packet boundary: release the lock and move priority past the owner.
                    if (sel_last) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        ptr_d   = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            ptr_q    <= '0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign o_tready = tready;
    assign o_tdata  = tdata_q;
    assign o_tlast  = tlast_q;
    assign o_tvalid = tvalid_q;
    assign o_grant  = grant_q;
    assign o_busy   = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_corescore_axis_arb.sv
// Directed bench for corescore_axis_arb (N=4): per-requester byte queues drive the inputs,
// accepted output bytes are logged and compared with hand-computed sequences.
module tb_corescore_axis_arb;

    localparam int N = 4;

    logic           i_clk;
    logic           i_rst;
    logic [N*8-1:0] i_tdata;
    logic [N-1:0]   i_tlast;
    logic [N-1:0]   i_tvalid;
    logic [N-1:0]   o_tready;
    logic [7:0]     o_tdata;
    logic           o_tlast;
    logic           o_tvalid;
    logic           i_tready;
    logic [N-1:0]   o_grant;
    logic           o_busy;

    corescore_axis_arb #(.N(N)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .o_tready (o_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .i_tready (i_tready),
        .o_grant  (o_grant),
        .o_busy   (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int         checks;
    int         errors;
    logic [8:0] src_mem [N][16];
    int         src_cnt [N];
    int         src_rd  [N];
    logic [N-1:0] src_en;
    logic [8:0] obs_log [32];
    logic [8:0] exp_log [32];
    int         obs_n;
    int         exp_n;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            if (src_en[k] && src_rd[k] < src_cnt[k]) begin
                i_tvalid[k]       = 1'b1;
                i_tdata[8*k +: 8] = src_mem[k][src_rd[k]][7:0];
                i_tlast[k]        = src_mem[k][src_rd[k]][8];
            end else begin
                i_tvalid[k]       = 1'b0;
                i_tdata[8*k +: 8] = 8'h00;
                i_tlast[k]        = 1'b0;
            end
        end
    endtask

    task automatic clear_all();
        for (int k = 0; k < N; k++) begin
            src_cnt[k] = 0;
            src_rd[k]  = 0;
        end
        src_en = '0;
        for (int i = 0; i < 32; i++) begin
            obs_log[i] = '0;
            exp_log[i] = '0;
        end
        obs_n = 0;
        exp_n = 0;
    endtask

    task automatic add(input int k, input logic [7:0] d, input logic l);
        src_mem[k][src_cnt[k]] = {l, d};
        src_cnt[k]++;
    endtask

    task automatic expect_byte(input logic [8:0] v);
        exp_log[exp_n] = v;
        exp_n++;
    endtask

    // One clock cycle: starts and ends on a falling edge with inputs already driven.
    task automatic tick();
        logic [N-1:0] hs;
        #1;
        hs = i_tvalid & o_tready;
        if (o_tvalid && i_tready && obs_n < 32) begin
            obs_log[obs_n] = {o_tlast, o_tdata};
            obs_n++;
        end
        @(posedge i_clk);
        @(negedge i_clk);
        for (int k = 0; k < N; k++) begin
            if (hs[k]) src_rd[k]++;
        end
        drive_inputs();
    endtask

    task automatic chk_log(input string tag);
        chk($sformatf("%s_count", tag), 32'(obs_n), 32'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(obs_log[i]), 32'(exp_log[i]));
        end
    endtask

    task automatic do_reset();
        i_rst    = 1'b1;
        i_tready = 1'b1;
        clear_all();
        drive_inputs();
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] vpat;
        logic [31:0] rpat;
        logic        viol;
        checks   = 0;
        errors   = 0;
        i_rst    = 1'b1;
        i_tready = 1'b1;
        clear_all();
        drive_inputs();

        // Reset values
        @(negedge i_clk);
        chk("rst_tvalid", 32'(o_tvalid), 0);
        chk("rst_tdata",  32'(o_tdata),  0);
        chk("rst_tlast",  32'(o_tlast),  0);
        chk("rst_tready", 32'(o_tready), 0);
        chk("rst_grant",  32'(o_grant),  0);
        chk("rst_busy",   32'(o_busy),   0);

        // Single source: requester 2 sends 11 22 33
        do_reset();
        add(2, 8'h11, 1'b0); add(2, 8'h22, 1'b0); add(2, 8'h33, 1'b1);
        src_en[2] = 1'b1;
        drive_inputs();
        #1 chk("single_idle_grant", 32'(o_grant), 0);
        tick();
        chk("single_grant",  32'(o_grant),  32'h4);
        chk("single_busy",   32'(o_busy),   1);
        chk("single_tready", 32'(o_tready), 32'h4);
        tick();
        chk("single_b0", 32'({o_tvalid, o_tlast, o_tdata}), 32'h211);
        tick();
        chk("single_b1", 32'({o_tvalid, o_tlast, o_tdata}), 32'h222);
        tick();
        chk("single_b2", 32'({o_tvalid, o_tlast, o_tdata}), 32'h333);
        chk("single_idle_busy", 32'(o_busy), 0);
        chk("single_ptr", 32'(dut.ptr_q), 3);
        tick();
        chk("single_drained", 32'(o_tvalid), 0);
        expect_byte(9'h011); expect_byte(9'h022); expect_byte(9'h133);
        chk_log("single_log");

        // Contention: requesters 0 and 1 pending from reset
        do_reset();
        add(0, 8'hA0, 1'b0); add(0, 8'hA1, 1'b1);
        add(1, 8'hB0, 1'b0); add(1, 8'hB1, 1'b1);
        src_en = 4'b0011;
        drive_inputs();
        vpat = '0;
        rpat = '0;
        for (int i = 0; i < 7; i++) begin
            tick();
            vpat[i] = o_tvalid;
            rpat[i] = |o_tready;
        end
        chk("contend_tvalid_pattern", vpat, 32'h36);
        chk("contend_tready_pattern", rpat, 32'h1B);
        chk("contend_ptr", 32'(dut.ptr_q), 2);
        expect_byte(9'h0A0); expect_byte(9'h1A1); expect_byte(9'h0B0); expect_byte(9'h1B1);
        chk_log("contend_log");

        // Lock: requester 3 arrives mid-packet of requester 1
        do_reset();
        add(1, 8'h10, 1'b0); add(1, 8'h11, 1'b0); add(1, 8'h12, 1'b0); add(1, 8'h13, 1'b1);
        src_en[1] = 1'b1;
        drive_inputs();
        tick();
        tick();
        add(3, 8'h30, 1'b0); add(3, 8'h31, 1'b1);
        src_en[3] = 1'b1;
        drive_inputs();
        viol = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 viol = viol | o_tready[3];
            tick();
        end
        chk("lock_tready3", 32'(viol), 0);
        tick();
        chk("lock_grant3", 32'(o_grant), 32'h8);
        for (int i = 0; i < 5; i++) tick();
        expect_byte(9'h010); expect_byte(9'h011); expect_byte(9'h012); expect_byte(9'h113);
        expect_byte(9'h030); expect_byte(9'h131);
        chk_log("lock_log");

        // Backpressure: sink stalls 3 cycles holding 5A
        do_reset();
        add(0, 8'h5A, 1'b0); add(0, 8'h5B, 1'b0); add(0, 8'h5C, 1'b1);
        src_en[0] = 1'b1;
        drive_inputs();
        tick();
        tick();
        chk("bp_first", 32'({o_tvalid, o_tdata}), 32'h15A);
        i_tready = 1'b0;
        #1 chk("bp_tready_drop", 32'(o_tready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_hold%0d", i), 32'({o_tvalid, o_tdata}), 32'h15A);
            chk($sformatf("bp_tready%0d", i), 32'(o_tready), 0);
        end
        i_tready = 1'b1;
        tick();
        chk("bp_drain_load", 32'({o_tvalid, o_tdata}), 32'h15B);
        for (int i = 0; i < 4; i++) tick();
        expect_byte(9'h05A); expect_byte(9'h05B); expect_byte(9'h15C);
        chk_log("bp_log");

        // Wrap: requester 3 finishes while 0 and 3 are pending
        do_reset();
        add(3, 8'hC0, 1'b1); add(3, 8'hC1, 1'b1);
        src_en[3] = 1'b1;
        drive_inputs();
        tick();
        chk("wrap_grant3", 32'(o_grant), 32'h8);
        add(0, 8'h01, 1'b1);
        src_en[0] = 1'b1;
        drive_inputs();
        tick();
        chk("wrap_ptr", 32'(dut.ptr_q), 0);
        tick();
        chk("wrap_grant0", 32'(o_grant), 32'h1);
        for (int i = 0; i < 4; i++) tick();
        expect_byte(9'h1C0); expect_byte(9'h101); expect_byte(9'h1C1);
        chk_log("wrap_log");

        // Reset pulse after byte 2 of 4
        do_reset();
        add(2, 8'h71, 1'b0); add(2, 8'h72, 1'b0); add(2, 8'h73, 1'b0); add(2, 8'h74, 1'b1);
        src_en[2] = 1'b1;
        drive_inputs();
        tick();
        tick();
        tick();
        chk("rmid_pre", 32'({o_tvalid, o_tdata}), 32'h172);
        i_rst = 1'b1;
        #1;
        chk("rmid_tvalid", 32'(o_tvalid), 0);
        chk("rmid_tdata",  32'(o_tdata),  0);
        chk("rmid_tlast",  32'(o_tlast),  0);
        chk("rmid_tready", 32'(o_tready), 0);
        chk("rmid_grant",  32'(o_grant),  0);
        chk("rmid_busy",   32'(o_busy),   0);
        clear_all();
        add(1, 8'h90, 1'b1);
        add(3, 8'h93, 1'b1);
        src_en = 4'b1010;
        drive_inputs();
        tick();
        i_rst = 1'b0;
        #1;
        chk("rmid_ptr", 32'(dut.ptr_q), 0);
        chk("rmid_still_idle", 32'(o_grant), 0);
        tick();
        chk("rmid_fresh_grant", 32'(o_grant), 32'h2);
        tick();
        chk("rmid_fresh_byte", 32'({o_tvalid, o_tlast, o_tdata}), 32'h390);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/corescore_axis_arb.md
# corescore_axis_arb

Packet-granular round-robin arbiter that shares one 8-bit AXI-Stream byte sink (UART emitter or the entry of the token ring) between N byte-stream requesters, typically the `wb2axis` outputs of several SERV tiles. Once a requester is granted, it owns the output until it transfers a byte with `tlast` set, so messages are never interleaved. The output is a single registered stage. The grant pointer rotates so every requester with a pending packet is served within N packets.

## Interface

Parameters:
- `N`, default 4: number of requesters, legal range 2..16.

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_tdata` in N*8: requester bytes; requester k occupies bits [8k+7:8k].
- `i_tlast` in N: per-requester last-byte-of-packet flag.
- `i_tvalid` in N: per-requester valid.
- `o_tready` out N: per-requester ready; at most one bit is high.
- `o_tdata` out 8: arbitrated byte.
- `o_tlast` out 1: arbitrated last flag.
- `o_tvalid` out 1: output valid.
- `i_tready` in 1: sink ready.
- `o_grant` out N: one-hot current owner; all zero when idle.
- `o_busy` out 1: high while in the LOCKED state.

## Operation

- State register: IDLE or LOCKED. The registers held are the grant `g` (one-hot), the round-robin pointer `ptr` (log2 N bits), and the output stage (`o_tdata`, `o_tlast`, `o_tvalid`).
- IDLE:
  - Search `i_tvalid` starting at index `ptr`, ascending, wrapping from N-1 to 0.
  - The first set bit k is loaded into `g`, and the state becomes LOCKED on the next edge.
  - If no bit is set, stay in IDLE.
  - In IDLE, `o_tready` is all zero.
- LOCKED:
  - `o_tready[k] = can_load` for the granted k; all other bits are 0.
  - `can_load = !o_tvalid || i_tready`.
- Input transfer: when `i_tvalid[k] && o_tready[k]`, load `o_tdata`/`o_tlast` from requester k and set `o_tvalid`.
- Packet end: if the transferred byte has `tlast=1`:
  - the next state is IDLE;
  - `g` is cleared;
  - `ptr` becomes (k+1) mod N.
- Output drain: when `o_tvalid && i_tready` and no new load occurs, clear `o_tvalid`.
- `o_tdata` and `o_tlast` hold their values while `o_tvalid && !i_tready`.
- Requester k deasserting `i_tvalid` mid-packet keeps the lock; the arbiter waits indefinitely. There is no timeout.
- Requesters must follow AXI-S rules: they hold data stable while valid and not ready. The arbiter does not check this.

## Timing

- Reset values:
  - state IDLE, `g` = 0, `ptr` = 0;
  - `o_tvalid` = 0, `o_tdata` = 0, `o_tlast` = 0;
  - `o_tready` = 0, `o_grant` = 0, `o_busy` = 0.
- Arbitration latency:
  - request visible in IDLE at edge 0;
  - `o_grant`/`o_tready` high after edge 1;
  - first byte on `o_tdata` after edge 2.
- Steady state with `i_tready=1`: one byte per cycle, full throughput.
- Between packets:
  - `tlast` is accepted at edge t;
  - the state is IDLE after t;
  - the next grant is valid after edge t+1;
  - this costs exactly one idle bubble cycle on `o_tready`.
- Backpressure: when `i_tready` is low with `o_tvalid` high, `o_tready` drops combinationally in the same cycle. No byte is lost or duplicated.
- Simultaneous drain and load: the output register is replaced and `o_tvalid` stays 1.
- Pointer wrap: when k = N-1, `ptr` becomes 0.
- Reset asserted mid-packet:
  - all state clears immediately;
  - a byte held in the output stage is discarded;
  - the requester sees `o_tready` fall asynchronously.

## Test plan

- Single source, N=4:
  - stimulus: requester 2 sends 0x11, 0x22, 0x33 (`tlast` on 0x33) with `i_tready=1`;
  - required: `o_grant` = 4'b0100 after cycle 1; outputs 0x11, 0x22, 0x33 on consecutive cycles from cycle 2, `o_tlast` only with 0x33; `ptr` = 3; IDLE afterwards.
- Contention:
  - stimulus: requesters 0 and 1 each hold a 2-byte packet from reset;
  - required: output is packet 0 fully, then packet 1, with exactly one bubble cycle between them.
- Lock:
  - stimulus: requester 3 raises valid in the middle of requester 1's 4-byte packet;
  - required: no requester-3 byte appears before requester 1's `tlast`, and `o_tready[3]` stays 0 throughout.
- Backpressure:
  - stimulus: `i_tready` is low for 3 cycles while `o_tvalid=1` with data 0x5A;
  - required: `o_tdata` holds 0x5A, `o_tready` stays 0, and every byte appears exactly once in the output sequence.
- Wrap:
  - stimulus: requester 3 completes a packet while requesters 0 and 3 are both pending;
  - required: `ptr` = 0 and the next grant goes to requester 0.
- Reset mid-packet:
  - stimulus: `i_rst` pulses after byte 2 of 4;
  - required: all outputs equal their reset values in the same cycle; a fresh request is granted 1 cycle after reset release with `ptr` = 0.
